// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: global freeze on memory stalls, branch flush
// (deferred across a freeze), load-use bubble insertion, and stall/flush
// performance counters.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        im_stall,
  input  logic        dm_stall,
  input  logic        ld_use,
  input  logic        br_taken,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idexe_we,
  output logic        idexe_flush,
  output logic        exemem_we,
  output logic        memwb_we,
  output logic        pc_redirect,
  output logic        frozen,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {RUN, MEMWAIT} state_t;

  state_t      state_q, state_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic mem_stall;
  logic branch;
  logic flush_apply;
  logic bubble_apply;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign mem_stall = im_stall | dm_stall;
  // A branch seen during a freeze is remembered so its flush lands on release.
  assign branch       = br_taken | br_pend_q;
  assign flush_apply  = ~rst & ~mem_stall & branch;
  assign bubble_apply = ~rst & ~mem_stall & ~branch & ld_use;

  // Pipeline register controls, priority rst > mem_stall > branch > ld_use.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idexe_we    = 1'b1;
    idexe_flush = 1'b0;
    exemem_we   = 1'b1;
    memwb_we    = 1'b1;
    pc_redirect = 1'b0;
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idexe_we    = 1'b0;
      exemem_we   = 1'b0;
      memwb_we    = 1'b0;
      ifid_flush  = 1'b1;
      idexe_flush = 1'b1;
    end else if (mem_stall) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idexe_we    = 1'b0;
      exemem_we   = 1'b0;
      memwb_we    = 1'b0;
    end else if (branch) begin
      pc_redirect = 1'b1;
      ifid_flush  = 1'b1;
      idexe_flush = 1'b1;
    end else if (ld_use) begin
      // Hold PC and IF/ID, inject a bubble into ID/EXE, let older stages drain.
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idexe_flush = 1'b1;
    end
  end

  // Next-state logic for the freeze FSM, pending branch and counters.
  always_comb begin
    state_d     = state_q;
    br_pend_d   = br_pend_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rst) begin
      state_d     = RUN;
      br_pend_d   = 1'b0;
      stall_cnt_d = 32'd0;
      flush_cnt_d = 16'd0;
    end else begin
      case (state_q)
        RUN:     state_d = mem_stall ? MEMWAIT : RUN;
        MEMWAIT: state_d = mem_stall ? MEMWAIT : RUN;
        default: state_d = RUN;
      endcase
      if (mem_stall) begin
        if (br_taken) br_pend_d = 1'b1;
      end else begin
        br_pend_d = 1'b0;
      end
      if (mem_stall || bubble_apply) stall_cnt_d = sat_inc32(stall_cnt_q);
      if (flush_apply)               flush_cnt_d = sat_inc16(flush_cnt_q);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    br_pend_q   <= br_pend_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign frozen    = (state_q == MEMWAIT);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst, im_stall, dm_stall, ld_use, br_taken;
  logic        pc_we, ifid_we, ifid_flush, idexe_we, idexe_flush;
  logic        exemem_we, memwb_we, pc_redirect, frozen;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [7:0]  ctrl;

  int checks   = 0;
  int failures = 0;

  // ctrl bit order: pc_we ifid_we ifid_flush idexe_we idexe_flush exemem_we memwb_we pc_redirect
  localparam logic [7:0] C_NORMAL = 8'b1101_0110;
  localparam logic [7:0] C_FREEZE = 8'b0000_0000;
  localparam logic [7:0] C_BRANCH = 8'b1111_1111;
  localparam logic [7:0] C_LDUSE  = 8'b0001_1110;
  localparam logic [7:0] C_RESET  = 8'b0010_1000;

  assign ctrl = {pc_we, ifid_we, ifid_flush, idexe_we, idexe_flush, exemem_we, memwb_we, pc_redirect};

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .im_stall(im_stall), .dm_stall(dm_stall),
    .ld_use(ld_use), .br_taken(br_taken), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idexe_we(idexe_we), .idexe_flush(idexe_flush),
    .exemem_we(exemem_we), .memwb_we(memwb_we), .pc_redirect(pc_redirect),
    .frozen(frozen), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s_im, input logic s_dm, input logic s_ld, input logic s_br);
    im_stall = s_im; dm_stall = s_dm; ld_use = s_ld; br_taken = s_br;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1, 0, 1, 1);
    #1;
    checks++;
    if (ctrl !== C_RESET) begin
      failures++; $display("FAIL reset_ctrl got=%b want=%b", ctrl, C_RESET);
    end
    step();
    set_in(0, 0, 0, 0);
    step();
    checks++;
    if (frozen !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state frozen=%b stall=%0d flush=%0d want 0/0/0", frozen, stall_cnt, flush_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    do_reset();
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (ctrl !== C_NORMAL) begin
        failures++; $display("FAIL idle_ctrl cyc=%0d got=%b want=%b", i, ctrl, C_NORMAL);
      end
      step();
    end
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 16'd0 || frozen !== 1'b0) begin
      failures++;
      $display("FAIL idle_cnt stall=%0d flush=%0d frozen=%b want 0/0/0", stall_cnt, flush_cnt, frozen);
    end
  endtask

  task automatic test_mem_stall();
    logic [7:0] exp_c;
    logic       exp_f;
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      set_in(0, (i <= 4), 0, 0);
      exp_c = (i <= 4) ? C_FREEZE : C_NORMAL;
      exp_f = (i >= 2 && i <= 5);
      #1;
      checks++;
      if (ctrl !== exp_c) begin
        failures++; $display("FAIL mstall_ctrl cyc=%0d got=%b want=%b", i, ctrl, exp_c);
      end
      checks++;
      if (frozen !== exp_f) begin
        failures++; $display("FAIL mstall_frozen cyc=%0d got=%b want=%b", i, frozen, exp_f);
      end
      step();
    end
    checks++;
    if (stall_cnt !== 32'd4) begin
      failures++; $display("FAIL mstall_cnt got=%0d want=4", stall_cnt);
    end
  endtask

  task automatic test_branch_in_freeze();
    do_reset();
    // br_taken pulses twice within one freeze: one flush expected on release
    for (int i = 1; i <= 4; i++) begin
      set_in(1, 0, 0, (i == 2 || i == 4));
      #1;
      checks++;
      if (ctrl !== C_FREEZE) begin
        failures++; $display("FAIL brfrz_hold cyc=%0d got=%b want=%b", i, ctrl, C_FREEZE);
      end
      step();
    end
    set_in(0, 0, 0, 0);
    #1;
    checks++;
    if (ctrl !== C_BRANCH) begin
      failures++; $display("FAIL brfrz_release got=%b want=%b", ctrl, C_BRANCH);
    end
    step();
    #1;
    checks++;
    if (ctrl !== C_NORMAL) begin
      failures++; $display("FAIL brfrz_after got=%b want=%b", ctrl, C_NORMAL);
    end
    step();
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 32'd4) begin
      failures++; $display("FAIL brfrz_cnt flush=%0d stall=%0d want 1/4", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_ld_use();
    do_reset();
    set_in(0, 0, 1, 0);
    #1;
    checks++;
    if (ctrl !== C_LDUSE) begin
      failures++; $display("FAIL lduse_ctrl got=%b want=%b", ctrl, C_LDUSE);
    end
    step();
    set_in(0, 0, 0, 0);
    #1;
    checks++;
    if (ctrl !== C_NORMAL) begin
      failures++; $display("FAIL lduse_next got=%b want=%b", ctrl, C_NORMAL);
    end
    checks++;
    if (stall_cnt !== 32'd1 || flush_cnt !== 16'd0) begin
      failures++; $display("FAIL lduse_cnt stall=%0d flush=%0d want 1/0", stall_cnt, flush_cnt);
    end
    step();
  endtask

  task automatic test_ld_use_in_freeze();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 1, 1, 0);
      #1;
      checks++;
      if (ctrl !== C_FREEZE) begin
        failures++; $display("FAIL ldfrz_hold cyc=%0d got=%b want=%b", i, ctrl, C_FREEZE);
      end
      step();
    end
    set_in(0, 0, 1, 0);
    #1;
    checks++;
    if (ctrl !== C_LDUSE) begin
      failures++; $display("FAIL ldfrz_release got=%b want=%b", ctrl, C_LDUSE);
    end
    step();
    set_in(0, 0, 0, 0);
    checks++;
    if (stall_cnt !== 32'd3) begin
      failures++; $display("FAIL ldfrz_cnt got=%0d want=3", stall_cnt);
    end
  endtask

  task automatic test_ld_and_branch();
    do_reset();
    set_in(0, 0, 1, 1);
    #1;
    checks++;
    if (ctrl !== C_BRANCH) begin
      failures++; $display("FAIL ldbr_ctrl got=%b want=%b", ctrl, C_BRANCH);
    end
    step();
    set_in(0, 0, 0, 0);
    #1;
    checks++;
    if (ctrl !== C_NORMAL) begin
      failures++; $display("FAIL ldbr_next got=%b want=%b", ctrl, C_NORMAL);
    end
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 32'd0) begin
      failures++; $display("FAIL ldbr_cnt flush=%0d stall=%0d want 1/0", flush_cnt, stall_cnt);
    end
    step();
  endtask

  task automatic test_reset_discards_pending();
    do_reset();
    set_in(1, 0, 0, 1);
    step();
    set_in(1, 0, 0, 0);
    step();
    checks++;
    if (frozen !== 1'b1) begin
      failures++; $display("FAIL rstpend_frozen got=%b want=1", frozen);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_RESET) begin
      failures++; $display("FAIL rstpend_rstctrl got=%b want=%b", ctrl, C_RESET);
    end
    step();
    rst = 1'b0;
    set_in(0, 0, 0, 0);
    #1;
    checks++;
    if (ctrl !== C_NORMAL) begin
      failures++; $display("FAIL rstpend_noflush got=%b want=%b", ctrl, C_NORMAL);
    end
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 16'd0 || frozen !== 1'b0) begin
      failures++;
      $display("FAIL rstpend_cnt stall=%0d flush=%0d frozen=%b want 0/0/0", stall_cnt, flush_cnt, frozen);
    end
    step();
    checks++;
    if (flush_cnt !== 16'd0) begin
      failures++; $display("FAIL rstpend_cnt2 flush=%0d want=0", flush_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    step();
    test_reset();
    test_idle();
    test_mem_stall();
    test_branch_in_freeze();
    test_ld_use();
    test_ld_use_in_freeze();
    test_ld_and_branch();
    test_reset_discards_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have these ports, one per line (name  direction  width  meaning):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- im_stall  in  1  instruction-memory AXI fetch incomplete this cycle.
- dm_stall  in  1  data-memory AXI access incomplete this cycle.
- ld_use  in  1  load-use hazard detected in ID (EXE is a load, EXE rd matches ID rs1/rs2).
- br_taken  in  1  EXE resolves a jump or taken branch this cycle.
- pc_we  out  1  PC register write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  IF/ID clear to NOP.
- idexe_we  out  1  ID/EXE register write enable.
- idexe_flush  out  1  ID/EXE clear to bubble (all control fields 0).
- exemem_we  out  1  EXE/MEM register write enable.
- memwb_we  out  1  MEM/WB register write enable.
- pc_redirect  out  1  PC mux selects the EXE branch target.
- frozen  out  1  registered: 1 while in state MEMWAIT.
- stall_cnt  out  32  stall-cycle performance counter.
- flush_cnt  out  16  applied-flush performance counter.

Function
REQ-002 The block SHALL define mem_stall = im_stall OR dm_stall.
REQ-003 The FSM SHALL have two states: RUN and MEMWAIT.
REQ-004 Transitions SHALL be: RUN->MEMWAIT when mem_stall=1; MEMWAIT stays while mem_stall=1; MEMWAIT->RUN when mem_stall=0.
REQ-005 Control outputs SHALL be combinational from the inputs, the state and br_pend, with priority: rst > mem_stall > branch > ld_use > normal.
REQ-006 mem_stall=1: all *_we=0, all flushes=0, pc_redirect=0 (global freeze, every pipeline register holds).
REQ-007 branch = br_taken OR br_pend, mem_stall=0: pc_we=1, pc_redirect=1, ifid_flush=1, idexe_flush=1, all other we=1.
REQ-008 ld_use=1, no branch, mem_stall=0: pc_we=0, ifid_we=0, idexe_flush=1, exemem_we=1, memwb_we=1.
REQ-009 Normal (no condition active): all *_we=1, all flushes=0, pc_redirect=0.
REQ-010 br_pend SHALL set when br_taken=1 and mem_stall=1.
REQ-011 br_pend SHALL clear in the cycle its flush is applied (mem_stall=0); br_taken falling during the freeze SHALL NOT cancel the pending flush.
REQ-012 Repeated br_taken during a single freeze SHALL yield exactly one flush on release.
REQ-013 ld_use SHALL be ignored during a freeze and re-evaluated in the release cycle.
REQ-014 ld_use and branch in the same cycle: the branch wins; no extra bubble cycle.
REQ-015 stall_cnt SHALL increment by 1 per cycle with mem_stall=1, or with REQ-008 active; it saturates at 0xFFFFFFFF.
REQ-016 flush_cnt SHALL increment by 1 per cycle in which REQ-007 applies; it saturates at 0xFFFF.
REQ-017 frozen SHALL equal 1 exactly when the state is MEMWAIT (one cycle after mem_stall rises).

Reset
REQ-018 rst=1 SHALL force on the next edge: state RUN, br_pend 0, stall_cnt 0, flush_cnt 0, frozen 0.
REQ-019 While rst=1, combinational outputs SHALL be: all *_we=0, ifid_flush=1, idexe_flush=1, pc_redirect=0.
REQ-020 rst asserted mid-freeze with br_pend=1 SHALL discard the pending flush; no flush follows reset release.

Verification
REQ-021 Idle, no stalls, 10 cycles -> all *_we=1, flushes 0, stall_cnt=0, flush_cnt=0.
REQ-022 dm_stall=1 for 4 cycles, then 0 -> all we=0 for 4 cycles; frozen=1 for cycles 2-5; stall_cnt=4.
REQ-023 im_stall=1, br_taken pulses 1 cycle inside the stall, stall ends 3 cycles later -> release cycle has pc_redirect=1, ifid_flush=1, idexe_flush=1; flush_cnt=1; br_pend=0 afterwards.
REQ-024 ld_use=1 for 1 cycle -> pc_we=0, ifid_we=0, idexe_flush=1 that cycle; stall_cnt=1; next cycle normal.
REQ-025 ld_use=1 and br_taken=1 together -> branch outputs only; flush_cnt=1; stall_cnt=0.
REQ-026 br_pend=1 during a freeze, rst for 1 cycle, then im_stall=0 -> no flush after reset; both counters read 0.
